// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrop
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small FIFO of {pc, instr} entries with synchronous reset and flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push && (count_q != FULL_CNT);
    assign pop_ok  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        // Flush wins over a same-cycle pop or push: the buffer simply empties.
        if (rst || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request at a time, redirect handling,
// and a small FIFO buffering fetched words for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e     state_q;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      req_pc_q;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign redirect_pc = branch_target & ~32'h0000_0003;

    // A redirect in the response cycle discards the word instead of buffering it.
    assign push       = (state_q == StWait) && imem_rvalid && !pcsrc;
    assign pop        = instr_valid && instr_ready;
    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(pcsrc),
        .push (push),
        .wdata(push_entry),
        .pop  (pop),
        .rdata(head),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            if (pcsrc) begin
                fetch_pc_q <= redirect_pc;
            end
            unique case (state_q)
                // Only one request is ever in flight, so a free slot now stays free for its response.
                StIdle: begin
                    if (!pcsrc && (count != FULL_CNT)) begin
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        req_pc_q <= fetch_pc_q;
                        if (!pcsrc) begin
                            fetch_pc_q <= fetch_pc_q + 32'(INSTR_BYTES);
                        end
                        state_q <= pcsrc ? StDrop : StWait;
                    end else if (pcsrc) begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        state_q <= StIdle;
                    end else if (pcsrc) begin
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (imem_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a switchable auto/manual memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic        auto_mode;
    logic        m_ack;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        acc_q;
    logic [31:0] acc_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Auto memory: acks every request at once, answers next cycle with ~address.
    always @(posedge clk) begin
        acc_q    <= imem_req && imem_ack;
        acc_addr <= imem_addr;
    end

    assign imem_ack    = auto_mode ? imem_req : m_ack;
    assign imem_rvalid = auto_mode ? acc_q : m_rvalid;
    assign imem_rdata  = auto_mode ? ~acc_addr : m_rdata;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .pcsrc        (pcsrc),
        .branch_target(branch_target),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pcsrc    = 1'b0;
        m_ack    = 1'b0;
        m_rvalid = 1'b0;
        nxt(2);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        auto_mode     = 1'b0;
        m_ack         = 1'b0;
        m_rvalid      = 1'b0;
        m_rdata       = '0;
        pcsrc         = 1'b0;
        branch_target = '0;
        instr_ready   = 1'b0;

        // Reset state, with reset overriding redirect/ack/rvalid
        pcsrc         = 1'b1;
        branch_target = 32'h0000_0040;
        m_ack         = 1'b1;
        m_rvalid      = 1'b1;
        m_rdata       = 32'h1111_1111;
        nxt(3);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        rst      = 1'b0;
        pcsrc    = 1'b0;
        m_ack    = 1'b0;
        m_rvalid = 1'b0;
        nxt(1);
        check("rst_prio_req", {31'd0, imem_req}, 32'd1);
        check("rst_prio_addr", imem_addr, 32'h0);

        // Prompt memory: addresses 0,4,8 and first valid 3 cycles after reset
        auto_mode   = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            nxt(1);
            check("seq_req", {31'd0, imem_req}, 32'd1);
            check("seq_addr", imem_addr, 32'(4 * k));
            check("seq_valid_early1", {31'd0, instr_valid}, 32'd0);
            nxt(1);
            check("seq_valid_early2", {31'd0, instr_valid}, 32'd0);
            nxt(1);
            check("seq_valid", {31'd0, instr_valid}, 32'd1);
            check("seq_pc", instr_pc, 32'(4 * k));
            check("seq_instr", instr, ~32'(4 * k));
        end

        // Backpressure: buffer fills to depth, fetch stalls, then resumes
        instr_ready = 1'b0;
        do_reset();
        nxt(10);
        check("full_req", {31'd0, imem_req}, 32'd0);
        check("full_valid", {31'd0, instr_valid}, 32'd1);
        check("full_head_pc", instr_pc, 32'h0);
        check("full_head_instr", instr, ~32'h0);
        instr_ready = 1'b1;
        nxt(1);
        instr_ready = 1'b0;
        check("full_pop_pc", instr_pc, 32'h4);
        check("full_pop_req", {31'd0, imem_req}, 32'd0);
        nxt(1);
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h8);

        // Redirect while waiting for data: flush, drop response, refetch at 0x100
        do_reset();
        nxt(3);
        auto_mode = 1'b0;
        check("wr_pre_valid", {31'd0, instr_valid}, 32'd1);
        nxt(1);
        check("wr_req", {31'd0, imem_req}, 32'd1);
        check("wr_addr", imem_addr, 32'h4);
        m_ack = 1'b1;
        nxt(1);
        m_ack         = 1'b0;
        pcsrc         = 1'b1;
        branch_target = 32'h0000_0103;
        nxt(1);
        pcsrc = 1'b0;
        check("wr_flush_valid", {31'd0, instr_valid}, 32'd0);
        check("wr_drop_req", {31'd0, imem_req}, 32'd0);
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEAD_BEEF;
        nxt(1);
        m_rvalid = 1'b0;
        check("wr_discard_valid", {31'd0, instr_valid}, 32'd0);
        nxt(1);
        check("wr_new_req", {31'd0, imem_req}, 32'd1);
        check("wr_new_addr", imem_addr, 32'h0000_0100);
        m_ack = 1'b1;
        nxt(1);
        m_ack    = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h1234_5678;
        nxt(1);
        m_rvalid = 1'b0;
        check("wr_new_valid", {31'd0, instr_valid}, 32'd1);
        check("wr_new_pc", instr_pc, 32'h0000_0100);
        check("wr_new_instr", instr, 32'h1234_5678);

        // Redirect together with ack at fetch_pc=8: next request goes to 0x40
        auto_mode   = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        nxt(7);
        check("ra_pre_addr", imem_addr, 32'h8);
        pcsrc         = 1'b1;
        branch_target = 32'h0000_0040;
        nxt(1);
        pcsrc = 1'b0;
        check("ra_req", {31'd0, imem_req}, 32'd0);
        check("ra_valid", {31'd0, instr_valid}, 32'd0);
        nxt(1);
        check("ra_drop_valid", {31'd0, instr_valid}, 32'd0);
        nxt(1);
        check("ra_next_req", {31'd0, imem_req}, 32'd1);
        check("ra_next_addr", imem_addr, 32'h0000_0040);
        nxt(2);
        check("ra_pc", instr_pc, 32'h0000_0040);
        check("ra_instr", instr, ~32'h0000_0040);

        // Address wrap from 0xFFFF_FFFC, target low bits ignored
        do_reset();
        pcsrc         = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        nxt(1);
        pcsrc = 1'b0;
        check("wrap_idle_req", {31'd0, imem_req}, 32'd0);
        check("wrap_align", imem_addr, 32'hFFFF_FFFC);
        nxt(1);
        check("wrap_req", {31'd0, imem_req}, 32'd1);
        nxt(2);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_instr", instr, 32'h0000_0003);
        nxt(1);
        check("wrap_next_addr", imem_addr, 32'h0);

        // Reset in WAIT with a late rvalid afterwards
        auto_mode   = 1'b0;
        instr_ready = 1'b0;
        do_reset();
        nxt(1);
        check("rw_req", {31'd0, imem_req}, 32'd1);
        m_ack = 1'b1;
        nxt(1);
        m_ack = 1'b0;
        rst   = 1'b1;
        nxt(1);
        rst      = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'hBAD0_BAD0;
        check("rw_rst_req", {31'd0, imem_req}, 32'd0);
        check("rw_rst_addr", imem_addr, 32'h0);
        nxt(1);
        m_rvalid = 1'b0;
        check("rw_late_valid", {31'd0, instr_valid}, 32'd0);
        check("rw_next_req", {31'd0, imem_req}, 32'd1);
        check("rw_next_addr", imem_addr, 32'h0);
        nxt(1);
        check("rw_still_empty", {31'd0, instr_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
